// File: rtl/scale_ratio_gen.sv
// scale_ratio_gen: run-time generator of fixed-point scaling ratios
// floor(src * 2^FRAC_W / dst). It has a single-ratio mode and a sweep mode
// that fills an external ratio RAM for dst = src+1 .. src+count.
// The divider is a restoring divider that produces one quotient bit per cycle.
module scale_ratio_gen #(
  parameter int SIZE_W = 11,
  parameter int FRAC_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              sweep,
  input  logic [SIZE_W-1:0] src_size,
  input  logic [SIZE_W-1:0] dst_size,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [FRAC_W-1:0] ratio,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [FRAC_W-1:0] wr_data
);

  localparam int BC_W = $clog2(FRAC_W) + 1;
  localparam int REM_W = SIZE_W + 2;
  localparam int DST_W = SIZE_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nx;

  // Latched request and divider working registers
  logic              mode_q;
  logic [SIZE_W-1:0] src_q;
  logic [DST_W-1:0]  dst_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] k_q;
  logic [REM_W-1:0]  rem_q;
  logic [FRAC_W-1:0] quo_q;
  logic [BC_W-1:0]   bitcnt;

  // One restoring step: shift, compare, conditionally subtract.
  // Remainder stays below dst, so the shifted value fits in REM_W bits.
  // Result is {quotient bit, new remainder}.
  function automatic logic [REM_W:0] div_step(input logic [REM_W-1:0] r,
                                              input logic [DST_W-1:0] d);
    logic [REM_W-1:0] sh;
    logic [REM_W-1:0] dx;
    sh = {r[REM_W-2:0], 1'b0};
    dx = {1'b0, d};
    if (sh >= dx) begin
      div_step = {1'b1, sh - dx};
    end else begin
      div_step = {1'b0, sh};
    end
  endfunction

  logic [REM_W:0]    step;
  logic [REM_W-1:0]  rem_nx;
  logic [FRAC_W-1:0] quo_nx;
  logic              last_bit;
  logic              last_entry;
  logic [DST_W-1:0]  dst_sweep_nx;
  logic              single_special;

  // Divider step and sequencing conditions
  always_comb begin
    step           = div_step(rem_q, dst_q);
    rem_nx         = step[REM_W-1:0];
    quo_nx         = {quo_q[FRAC_W-2:0], step[REM_W]};
    last_bit       = (bitcnt == BC_W'(FRAC_W - 1));
    last_entry     = (k_q == cnt_q);
    dst_sweep_nx   = {1'b0, src_q} + DST_W'(k_q) + DST_W'(1);
    single_special = (dst_size == '0) || (dst_size <= src_size);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (sweep) begin
            state_nx = (count == '0) ? S_DONE : S_CALC;
          end else begin
            state_nx = single_special ? S_DONE : S_CALC;
          end
        end
      end
      S_CALC: begin
        if (last_bit) begin
          state_nx = mode_q ? S_WRITE : S_DONE;
        end
      end
      S_WRITE: begin
        state_nx = last_entry ? S_DONE : S_CALC;
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Status strobes decoded straight from the state, so reset clears them
  always_comb begin
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
    wr_en = (state == S_WRITE);
  end

  // Operand capture, divider iteration and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err     <= 1'b0;
      ratio   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= sweep;
            src_q  <= src_size;
            cnt_q  <= count;
            k_q    <= ADDR_W'(1);
            rem_q  <= {2'b00, src_size};
            quo_q  <= '0;
            bitcnt <= '0;
            err    <= 1'b0;
            if (sweep) begin
              dst_q <= {1'b0, src_size} + DST_W'(1);
            end else begin
              dst_q <= {1'b0, dst_size};
              if (dst_size == '0) begin
                err   <= 1'b1;
                ratio <= '0;
              end else if (dst_size <= src_size) begin
                ratio <= '1;
              end
            end
          end
        end
        S_CALC: begin
          rem_q  <= rem_nx;
          quo_q  <= quo_nx;
          bitcnt <= bitcnt + BC_W'(1);
          if (last_bit) begin
            ratio <= quo_nx;
            if (mode_q) begin
              wr_addr <= k_q;
              wr_data <= quo_nx;
            end
          end
        end
        S_WRITE: begin
          if (!last_entry) begin
            k_q    <= k_q + ADDR_W'(1);
            dst_q  <= dst_sweep_nx;
            rem_q  <= {2'b00, src_q};
            quo_q  <= '0;
            bitcnt <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scale_ratio_gen.sv
// Scoreboard bench for scale_ratio_gen: the driver pushes the expected write
// and done events with their cycle stamps, a monitor pops and compares them.
module tb_scale_ratio_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sweep = 1'b0;
  logic [10:0] src_size = '0;
  logic [10:0] dst_size = '0;
  logic [9:0]  count = '0;
  logic        busy, done, err, wr_en;
  logic [15:0] ratio, wr_data;
  logic [9:0]  wr_addr;

  scale_ratio_gen #(.SIZE_W(11), .FRAC_W(16), .ADDR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sweep(sweep),
    .src_size(src_size), .dst_size(dst_size), .count(count),
    .busy(busy), .done(done), .err(err), .ratio(ratio),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_wr;
    int addr;
    int data;
    bit err;
    int cyc;
  } ev_t;

  ev_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] last_ratio = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input longint act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with no matching expected event (cycle %0d)", name, act, cyc);
  endtask

  function automatic int model(input int s, input int d);
    longint num;
    num = longint'(s) << 16;
    return int'(num / d);
  endfunction

  // Monitor: compares every write and done event against the scoreboard
  initial begin
    ev_t e;
    bit prev_wr;
    prev_wr = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (wr_en) begin
        chk("wr_consecutive", prev_wr, 0);
        if (sb.size() == 0 || !sb[0].is_wr) begin
          fail("wr_unexpected", wr_addr);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", wr_addr, e.addr);
          chk("wr_data", wr_data, e.data);
          chk("wr_cycle", cyc, e.cyc);
        end
      end
      prev_wr = wr_en;
      if (done) begin
        if (sb.size() == 0 || sb[0].is_wr) begin
          fail("done_unexpected", ratio);
        end else begin
          e = sb.pop_front();
          chk("done_ratio", ratio, e.data);
          chk("done_err", err, e.err);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      chk("busy_active", busy, 1);
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      fail("done_timeout", n);
    end else begin
      chk("busy_at_done", busy, 1);
    end
    @(posedge clk);
    #1;
    chk("busy_idle", busy, 0);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic run_single(input int s, input int d, input int exp_ratio,
                            input bit exp_err, input int lat);
    int t0;
    @(negedge clk);
    sweep = 1'b0; src_size = 11'(s); dst_size = 11'(d); count = '0; start = 1'b1;
    t0 = cyc;
    sb.push_back('{1'b0, 0, exp_ratio, exp_err, t0 + lat});
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat + 5);
    last_ratio = 16'(exp_ratio);
  endtask

  task automatic push_sweep(input int s, input int c, input int t0);
    int d;
    for (int k = 1; k <= c; k++) begin
      d = model(s, s + k);
      if (s == 480 && k == 1)   d = 'hFF77;
      if (s == 480 && k == 32)  d = 'hF000;
      if (s == 480 && k == 240) d = 'hAAAA;
      sb.push_back('{1'b1, k, d, 1'b0, t0 + 17 * k});
    end
    if (c > 0) last_ratio = 16'(sb[sb.size() - 1].data);
    sb.push_back('{1'b0, 0, int'(last_ratio), 1'b0, t0 + 17 * c + 1});
  endtask

  task automatic run_sweep(input int s, input int c);
    int t0;
    @(negedge clk);
    sweep = 1'b1; src_size = 11'(s); dst_size = '0; count = 10'(c); start = 1'b1;
    t0 = cyc;
    push_sweep(s, c, t0);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(17 * c + 10);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_ratio"}, ratio, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
  endtask

  // Driver: directed sequence
  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_single(480, 512, 'hF000, 1'b0, 17);
    run_single(480, 720, 'hAAAA, 1'b0, 17);
    run_single(480, 481, 'hFF77, 1'b0, 17);
    run_single(480, 480, 'hFFFF, 1'b0, 1);
    run_sweep(480, 0);
    run_single(480, 0, 'h0000, 1'b1, 1);
    run_single(0, 100, 'h0000, 1'b0, 17);

    // Start pulsed during CALC with different operands must be ignored
    @(negedge clk);
    sweep = 1'b0; src_size = 11'd480; dst_size = 11'd512; start = 1'b1;
    t0 = cyc;
    sb.push_back('{1'b0, 0, 'hF000, 1'b0, t0 + 17});
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sweep = 1'b1; src_size = 11'd100; dst_size = 11'd300; count = 10'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(20);
    last_ratio = 16'hF000;

    run_sweep(480, 240);
    chk("ratio_after_sweep", ratio, 'hAAAA);

    // Reset in the middle of a long sweep
    @(negedge clk);
    sweep = 1'b1; src_size = 11'd480; count = 10'd240; start = 1'b1;
    t0 = cyc;
    push_sweep(480, 240, t0);
    @(posedge clk);
    #1;
    start = 1'b0;
    while (cyc < t0 + 100) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("post_reset_idle", busy, 0);
    run_single(480, 720, 'hAAAA, 1'b0, 17);

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/scale_ratio_gen.md
# scale_ratio_gen

Sequential generator of fixed-point scaling ratios, ratio = floor(src_size × 2^FRAC_W / dst_size), for the video scaler datapath. It replaces hard-coded per-resolution ratio tables with run-time computation. It has two modes:
- **Single mode:** computes one ratio on request.
- **Sweep mode:** fills an external ratio RAM for dst = src+1 … src+count through a write port.

It sits between the scaler control registers and the scaler's coefficient RAM / ratio input.

## Interface
Parameters:
- SIZE_W, default 11: width of src/dst sizes.
- FRAC_W, default 16: ratio fraction bits; ratio output width.
- ADDR_W, default 10: sweep count and RAM address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request pulse; accepted only when busy=0.
- sweep  in  1  mode select, sampled with start (0 single, 1 sweep).
- src_size  in  SIZE_W  source size, sampled with start.
- dst_size  in  SIZE_W  destination size, single mode, sampled with start.
- count  in  ADDR_W  number of sweep entries, sampled with start.
- busy  out  1  high from cycle after accept through DONE cycle.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done when single-mode dst_size=0; held until next accept.
- ratio  out  FRAC_W  last computed ratio; held until next update.
- wr_en  out  1  sweep RAM write strobe, one cycle per entry.
- wr_addr  out  ADDR_W  entry index k (1..count).
- wr_data  out  FRAC_W  ratio for dst = src+k.

## Operation
- **States:** IDLE, CALC, WRITE, DONE.
- **Reset values:** busy=0, done=0, err=0, ratio=0, wr_en=0, wr_addr=0, wr_data=0; state=IDLE.
- **Accept:** start=1 in IDLE. Operands are latched. err clears on accept. start while busy=1 is ignored, with no effect.
- **Divider:** restoring, one quotient bit per cycle, MSB first.
  - Remainder register is SIZE_W+2 bits. It initialises to src, because src<dst guarantees an integer part of 0.
  - Per step: r ← r<<1; if r ≥ dst then r ← r−dst and q bit = 1.
  - Exactly FRAC_W CALC cycles per ratio.
- **Single mode:**
  - dst_size=0 → DONE next cycle with err=1, ratio=0.
  - dst_size ≤ src_size (ratio ≥ 1.0) → DONE next cycle with ratio = all-ones, err=0.
  - Otherwise CALC → DONE; ratio loads the quotient on entering DONE.
  - src_size=0 with dst>0 goes through CALC and gives ratio=0.
- **Sweep mode:**
  - Internal dst = src+k, computed at SIZE_W+1 bits so there is no overflow.
  - For k=1..count: CALC (FRAC_W cycles) → WRITE.
  - In WRITE: wr_en=1, wr_addr=k, wr_data=quotient; ratio also loads the quotient.
  - After k=count: DONE.
  - count=0 → DONE next cycle, no writes.
  - Address 0 is never written.
  - err is never set in sweep mode.
- **DONE:** done=1 for one cycle, then IDLE.
- **Reset mid-operation:** the next edge with rst_n=0 returns to IDLE with all outputs at reset values. A partially filled sweep is abandoned, with no further writes.

## Timing
Cycle 0 is the accept edge.
- **Single, normal:** CALC cycles 1..FRAC_W; done=1 in cycle FRAC_W+1 (17 at default).
- **Single, special case** (dst=0 or dst≤src): done=1 in cycle 1.
- **Sweep:**
  - Entry k writes in cycle k×(FRAC_W+1).
  - done=1 in cycle count×(FRAC_W+1)+1.
- busy=1 from cycle 1 through the done cycle. A new start is accepted in the first cycle after done (IDLE).
- wr_en is never high in consecutive cycles.
- ratio and wr_data are stable from their update edge until the next update.

## Test plan
- **Single normal:** src=480, dst=512 → cycle 17: done=1, ratio=0xF000, err=0; busy=1 in cycles 1..17.
- **Single normal:** src=480, dst=720 → ratio=0xAAAA. src=480, dst=481 → 0xFF77.
- **Special cases:**
  - dst=480, src=480 → cycle 1: done=1, ratio=0xFFFF, err=0.
  - dst=0 → cycle 1: done=1, err=1, ratio=0.
- **Sweep:** src=480, count=240 → 240 writes, addr 1=0xFF77, addr 32=0xF000, addr 240=0xAAAA; write k in cycle 17k; done in cycle 4081; ratio=0xAAAA afterward.
- **Busy and degenerate cases:**
  - start pulsed during CALC with different operands → ignored; result matches the first request.
  - Sweep count=0 → done cycle 1, no wr_en.
- **Reset mid-sweep:** rst_n=0 at cycle 100 of a count=240 sweep → all outputs at reset values next edge, no further wr_en. A fresh single request then produces a correct ratio.
